// File: rtl/a_delay_pipe_pkg.sv
// a_delay_pipe_pkg: operand-sum width and result fitting for a_delay_pipe.
// Saturating fit is selected by the A_DELAY_PIPE_SAT_EN build of the top.
package a_delay_pipe_pkg;

  localparam int G_DELAY_MAX = 64;
  localparam int FIT_W = 128;

  function automatic int sum_width(input int w1, input int w2);
    return ((w1 > w2 + 2) ? w1 : w2 + 2) + 1;
  endfunction

  function automatic logic [FIT_W-1:0] fit_mask(input int rw);
    return {FIT_W{1'b1}} >> (FIT_W - rw);
  endfunction

  // Bits above rw are either dropped (wrap) or collapse to all ones (sat).
  function automatic logic [FIT_W-1:0] fit_result(
    input logic [FIT_W-1:0] sum,
    input int               rw,
    input logic             sat
  );
    logic [FIT_W-1:0] mask;
    mask = fit_mask(rw);
    if (sat && ((sum & ~mask) != '0)) return mask;
    return sum & mask;
  endfunction

  function automatic logic fit_ovf(
    input logic [FIT_W-1:0] sum,
    input int               rw
  );
    return (sum & ~fit_mask(rw)) != '0;
  endfunction

endpackage

// File: rtl/a_delay_pipe_stage.sv
// a_delay_pipe_stage: one valid/data register of the elastic delay pipe.
// Flush clears valid only; data holds until the next load.
module a_delay_pipe_stage
  import a_delay_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic         valid_d_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (adv_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

endmodule

// File: rtl/a_delay_pipe.sv
// a_delay_pipe: elastic g_delay-stage pipe delivering d1+d2 on d3.
// Define A_DELAY_PIPE_SAT_EN for saturating results and the ovf output.
module a_delay_pipe
  import a_delay_pipe_pkg::*;
#(
  parameter int g_w2    = 32,
  parameter int g_w3    = 16,
  parameter int g_w1    = 8,
  parameter int g_delay = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [g_w1-1:0]                d1,
  input  logic [g_w2+1:0]                d2,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [g_w3*2-1:0]              d3,
  output logic [$clog2(g_delay+1)-1:0]   occ
`ifdef A_DELAY_PIPE_SAT_EN
  ,
  output logic                           ovf
`endif
);

  localparam int SW = sum_width(g_w1, g_w2);
  localparam int RW = g_w3 * 2;
  localparam int OW = $clog2(g_delay + 1);
  localparam int L  = g_delay - 1;
`ifdef A_DELAY_PIPE_SAT_EN
  localparam int DW = RW + 1;
`else
  localparam int DW = RW;
`endif

  if (g_delay < 1 || g_delay > G_DELAY_MAX) begin : g_bad_delay
    $error("a_delay_pipe: g_delay out of range");
  end

  logic [SW-1:0]      sum;
  logic [DW-1:0]      din;
  logic [g_delay-1:0] v;
  logic [g_delay-1:0] v_d;
  logic [g_delay-1:0] adv;
  logic [g_delay-1:0] load;
  logic [DW-1:0]      sin   [g_delay];
  logic [DW-1:0]      sdata [g_delay];
  logic [OW-1:0]      occ_q;
  logic [OW-1:0]      occ_d;

  assign sum = SW'(d1) + SW'(d2);

`ifdef A_DELAY_PIPE_SAT_EN
  assign din = {fit_ovf(FIT_W'(sum), RW),
                RW'(fit_result(FIT_W'(sum), RW, 1'b1))};
`else
  assign din = RW'(fit_result(FIT_W'(sum), RW, 1'b0));
`endif

  // A stage moves if the consumer takes the tail or any later slot is a hole.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int i = L; i >= 0; i--) begin
      adv[i] = v[i] & go;
      go     = go | ~v[i];
    end
  end

  assign in_ready = ~rst & ~flush & (~v[0] | adv[0]);

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int i = 1; i < g_delay; i++) begin
      load[i] = adv[i-1];
    end
  end

  for (genvar i = 0; i < g_delay; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign sin[i] = din;
    end else begin : g_body
      assign sin[i] = sdata[i-1];
    end

    a_delay_pipe_stage #(
      .W(DW)
    ) u_stage (
      .clk_i    (clk),
      .rst_i    (rst),
      .flush_i  (flush),
      .load_i   (load[i]),
      .adv_i    (adv[i]),
      .data_i   (sin[i]),
      .valid_o  (v[i]),
      .valid_d_o(v_d[i]),
      .data_o   (sdata[i])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < g_delay; i++) begin
      occ_d = occ_d + OW'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign out_valid = v[L];
  assign d3        = sdata[L][RW-1:0];
`ifdef A_DELAY_PIPE_SAT_EN
  assign ovf       = sdata[L][RW];
`endif

endmodule

// File: tb/tb_a_delay_pipe.sv
// tb_a_delay_pipe: table vectors, directed corner sequences and random
// traffic against a slot-position queue model of the elastic pipe.
module tb_a_delay_pipe;

  localparam int W1  = 8;
  localparam int W2  = 32;
  localparam int W3  = 16;
  localparam int DLY = 5;
  localparam int RW  = 2 * W3;
  localparam int OW  = $clog2(DLY + 1);
  localparam int L   = DLY - 1;
`ifdef A_DELAY_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [W1-1:0] d1 = '0;
  logic [W2+1:0] d2 = '0;
  logic          in_ready;
  logic          out_valid;
  logic [RW-1:0] d3;
  logic [OW-1:0] occ;
`ifdef A_DELAY_PIPE_SAT_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  a_delay_pipe #(
    .g_w2(W2), .g_w3(W3), .g_w1(W1), .g_delay(DLY)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d1(d1), .d2(d2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .d3(d3), .occ(occ)
`ifdef A_DELAY_PIPE_SAT_EN
    , .ovf(ovf)
`endif
  );

  typedef struct {
    logic [RW-1:0] d;
    logic          o;
    int            pos;
  } beat_t;

  typedef struct {
    logic [W1-1:0] a;
    logic [W2+1:0] b;
    logic [RW-1:0] ew;
    logic [RW-1:0] es;
    logic          eo;
  } vec_t;

  beat_t         q[$];
  int            np[$];
  logic [RW-1:0] got[$];
  int            checks = 0;
  int            failures = 0;
  logic          s_ir, s_ov;
  logic [RW-1:0] s_d3;
  logic [OW-1:0] s_occ;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW:0] ref_fit(input logic [W1-1:0] a,
                                          input logic [W2+1:0] b);
    longint unsigned s;
    s = 64'(a) + 64'(b);
    if (s >= (64'd1 << RW)) begin
      if (SAT) return {1'b1, {RW{1'b1}}};
    end
    return {1'b0, RW'(s)};
  endfunction

  // New slot of every queued beat: advance one slot, never onto the beat ahead.
  function automatic void plan(input logic ordy);
    int lim;
    int p;
    bit hout;
    lim = L;
    np.delete();
    hout = q.size() > 0 && q[0].pos == L && ordy;
    foreach (q[k]) begin
      if (k == 0 && hout) begin
        np.push_back(-1);
      end else begin
        p = q[k].pos + 1;
        if (p > lim) p = lim;
        np.push_back(p);
        lim = p - 1;
      end
    end
  endfunction

  function automatic bit m_ready();
    if (flush) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return np[np.size()-1] != 0;
  endfunction

  task automatic tick();
    bit    e_ir, e_ov, acc;
    beat_t nq[$];
    beat_t b;
    logic [RW:0] f;
    @(negedge clk);
    plan(out_ready);
    e_ir  = m_ready();
    e_ov  = q.size() > 0 && q[0].pos == L;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_d3  = d3;
    s_occ = occ;
    chk("in_ready", 64'(in_ready), 64'(e_ir));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("occ", 64'(occ), 64'(q.size()));
    if (e_ov) begin
      chk("d3", 64'(d3), 64'(q[0].d));
`ifdef A_DELAY_PIPE_SAT_EN
      chk("ovf", 64'(ovf), 64'(q[0].o));
`endif
    end
    acc = in_valid && e_ir;
    if (s_ov && out_ready) got.push_back(s_d3);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      foreach (q[k]) begin
        if (np[k] >= 0) begin
          b = q[k];
          b.pos = np[k];
          nq.push_back(b);
        end
      end
      if (acc) begin
        f = ref_fit(d1, d2);
        b.d = f[RW-1:0];
        b.o = f[RW];
        b.pos = 0;
        nq.push_back(b);
      end
      q = nq;
    end
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (DLY + 3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   n, lat, first;

    vt[0] = '{8'hFF, 34'h0_0000_0001, 32'h0000_0100, 32'h0000_0100, 1'b0};
    vt[1] = '{8'h01, 34'h3_FFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vt[2] = '{8'h00, 34'h0_0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[3] = '{8'hFF, 34'h0_FFFF_FFFF, 32'h0000_00FE, 32'hFFFF_FFFF, 1'b1};
    vt[4] = '{8'h12, 34'h0_0000_1000, 32'h0000_1012, 32'h0000_1012, 1'b0};
    vt[5] = '{8'h80, 34'h2_0000_0005, 32'h0000_0085, 32'hFFFF_FFFF, 1'b1};
    vt[6] = '{8'h00, 34'h0_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    // reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_d3", 64'(d3), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(s_ir), 64'd1);

    // first beat: latency and occupancy
    out_ready = 1'b1;
    in_valid = 1'b1; d1 = 8'hFF; d2 = 34'h1;
    tick();
    chk("lat_accept", 64'(s_ir), 64'd1);
    in_valid = 1'b0;
    for (int k = 1; k <= DLY; k++) begin
      tick();
      chk("lat_occ", 64'(s_occ), 64'd1);
      chk("lat_valid", 64'(s_ov), 64'(k == DLY));
      if (k == DLY) chk("lat_d3", 64'(s_d3), 64'h100);
    end
    drain();

    // arithmetic table
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; d1 = vt[i].a; d2 = vt[i].b; out_ready = 1'b1;
      tick();
      chk("tbl_accept", 64'(s_ir), 64'd1);
      in_valid = 1'b0;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!s_ov && lat < 20);
      chk("tbl_latency", 64'(lat), 64'(DLY));
      chk("tbl_d3", 64'(s_d3), 64'(SAT ? vt[i].es : vt[i].ew));
`ifdef A_DELAY_PIPE_SAT_EN
      chk("tbl_ovf", 64'(ovf), 64'(vt[i].eo));
`endif
    end
    drain();

    // stall and fill
    out_ready = 1'b0; d2 = '0; n = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; d1 = W1'(n + 1);
      tick();
      if (s_ir) n++;
      if (s_ov) chk("stall_d3_stable", 64'(s_d3), 64'd1);
    end
    chk("fill_accepts", 64'(n), 64'(DLY));
    chk("fill_in_ready", 64'(s_ir), 64'd0);
    chk("fill_occ", 64'(s_occ), 64'(DLY));
    got.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; d1 = W1'(n + 1);
    tick();
    chk("release_in_ready", 64'(s_ir), 64'd1);
    if (s_ir) n++;
    for (int k = 0; k < 20; k++) begin
      in_valid = (n < 7); d1 = W1'(n + 1);
      tick();
      if (s_ir && in_valid) n++;
    end
    chk("fill_out_count", 64'(got.size()), 64'd7);
    for (int i = 0; i < 7 && i < got.size(); i++)
      chk("fill_order", 64'(got[i]), 64'(i + 1));
    drain();

    // bubble collapse behind a stalled head
    out_ready = 1'b0; in_valid = 1'b1; d1 = 8'h0A; d2 = '0;
    tick();
    in_valid = 1'b0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k == 2); d1 = 8'h0B;
      tick();
      if (s_ov && first == 0) first = k;
    end
    chk("bubble_head_lat", 64'(first), 64'(DLY));
    chk("bubble_d3", 64'(s_d3), 64'h0A);
    chk("bubble_occ", 64'(s_occ), 64'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bubble_out_a", 64'(s_d3), 64'h0A);
    tick();
    chk("bubble_out_b_valid", 64'(s_ov), 64'd1);
    chk("bubble_out_b", 64'(s_d3), 64'h0B);
    drain();

    // flush with three beats in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; d1 = W1'(8'h21 + k);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; d1 = 8'h99;
    tick();
    chk("flush_in_ready", 64'(s_ir), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_occ", 64'(s_occ), 64'd0);
    chk("flush_out_valid", 64'(s_ov), 64'd0);
    got.delete();
    repeat (10) tick();
    chk("flush_no_emit", 64'(got.size()), 64'd0);

    // asynchronous reset mid-burst
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; d1 = W1'(k); d2 = 34'h40;
      tick();
    end
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; d1 = 8'h33; d2 = 34'h0;
    tick();
    in_valid = 1'b0; lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_ov && lat < 20);
    chk("arst_relat", 64'(lat), 64'(DLY));
    chk("arst_d3", 64'(s_d3), 64'h33);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(49, 0) == 0);
      d1 = W1'($urandom);
      d2 = (W2 + 2)'({$urandom, $urandom});
      if ($urandom_range(3, 0) == 0) d2 = {(W2 + 2){1'b1}};
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
